// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: RR-stage interlock and LM/SM micro-op sequencer.
// Detects load-use hazards that forwarding cannot cover (stall + bubble for one
// cycle) and expands LM/SM into one micro-op per set mask bit, holding the
// upstream registers until the last micro-op issues. All stall/bubble/micro-op
// outputs are Mealy (combinational from state and inputs) and forced to 0
// while rst_n is low.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_rr_op,
    input  logic [2:0]       id_rr_regA,
    input  logic [2:0]       id_rr_regB,
    input  logic [7:0]       id_rr_imm,
    input  logic [5:0]       rr_ex_op,
    input  logic [2:0]       rr_ex_regA,
    input  logic             flush,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_rr_stall,
    output logic             rr_ex_bubble,
    output logic             lmsm_valid,
    output logic [2:0]       lmsm_reg,
    output logic [2:0]       lmsm_offset,
    output logic             lmsm_first,
    output logic             lmsm_last,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OPC_ADD = 4'b0000;  // ADD/ADC/ADZ
    localparam logic [3:0] OPC_ADI = 4'b0001;
    localparam logic [3:0] OPC_NDU = 4'b0010;  // NDU/NDC/NDZ
    localparam logic [3:0] OPC_LW  = 4'b0100;
    localparam logic [3:0] OPC_SW  = 4'b0101;
    localparam logic [3:0] OPC_LM  = 4'b0110;
    localparam logic [3:0] OPC_SM  = 4'b0111;
    localparam logic [3:0] OPC_JLR = 4'b1001;
    localparam logic [3:0] OPC_BEQ = 4'b1100;
    localparam logic [5:0] OP_ADZ  = 6'b000001;
    localparam logic [5:0] OP_NDZ  = 6'b001001;

    typedef enum logic {IDLE, SEQ} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mask_q, mask_nxt;
    logic [2:0]       off_q, off_nxt;
    logic [CNT_W-1:0] cnt_q;

    logic       reads_a, reads_b, rr_is_lmsm, lu;
    logic       stall_c, bubble_c, valid_c, first_c, last_c;
    logic [2:0] reg_c, off_c;

    // Index of the lowest set bit (0 for an empty mask; callers guard that case).
    function automatic logic [2:0] low_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // True when at least two bits are set in the mask.
    function automatic logic multi_bit(input logic [7:0] m);
        return |(m & (m - 8'd1));
    endfunction

    // Decode which source fields the RR instruction actually reads.
    always_comb begin
        reads_a = 1'b0;
        reads_b = 1'b0;
        case (id_rr_op[5:2])
            OPC_ADD, OPC_NDU: begin reads_a = 1'b1; reads_b = 1'b1; end
            OPC_ADI, OPC_LM, OPC_SM: reads_a = 1'b1;
            OPC_SW, OPC_BEQ: begin reads_a = 1'b1; reads_b = 1'b1; end
            OPC_LW, OPC_JLR: reads_b = 1'b1;
            default: ;
        endcase
    end

    assign rr_is_lmsm = (id_rr_op[5:2] == OPC_LM) || (id_rr_op[5:2] == OPC_SM);

    // ADZ/NDZ consume the load's zero flag, so they interlock on any LW in EX.
    assign lu = (rr_ex_op[5:2] == OPC_LW) &&
                ((reads_a && (rr_ex_regA == id_rr_regA)) ||
                 (reads_b && (rr_ex_regA == id_rr_regB)) ||
                 (id_rr_op == OP_ADZ) || (id_rr_op == OP_NDZ));

    // Next-state and Mealy outputs; priority flush > load-use > LM/SM sequencing.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        off_nxt   = off_q;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        valid_c   = 1'b0;
        first_c   = 1'b0;
        last_c    = 1'b0;
        reg_c     = 3'd0;
        off_c     = 3'd0;
        if (flush) begin
            bubble_c  = 1'b1;
            state_nxt = IDLE;
            mask_nxt  = 8'd0;
            off_nxt   = 3'd0;
        end else if (lu) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_is_lmsm) begin
                        if (id_rr_imm == 8'd0) begin
                            bubble_c = 1'b1;
                        end else begin
                            valid_c = 1'b1;
                            first_c = 1'b1;
                            reg_c   = low_idx(id_rr_imm);
                            if (multi_bit(id_rr_imm)) begin
                                stall_c   = 1'b1;
                                mask_nxt  = id_rr_imm & (id_rr_imm - 8'd1);
                                off_nxt   = 3'd1;
                                state_nxt = SEQ;
                            end else begin
                                last_c = 1'b1;
                            end
                        end
                    end
                end
                SEQ: begin
                    valid_c  = 1'b1;
                    reg_c    = low_idx(mask_q);
                    off_c    = off_q;
                    mask_nxt = mask_q & (mask_q - 8'd1);
                    off_nxt  = off_q + 3'd1;
                    if (multi_bit(mask_q)) begin
                        stall_c = 1'b1;
                    end else begin
                        last_c    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sequencer state and saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= 8'd0;
            off_q  <= 3'd0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            mask_q <= mask_nxt;
            off_q  <= off_nxt;
            if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Reset forces every output low even though the outputs are combinational.
    assign pc_stall     = rst_n & stall_c;
    assign if_id_stall  = rst_n & stall_c;
    assign id_rr_stall  = rst_n & stall_c;
    assign rr_ex_bubble = rst_n & bubble_c;
    assign lmsm_valid   = rst_n & valid_c;
    assign lmsm_first   = rst_n & first_c;
    assign lmsm_last    = rst_n & last_c;
    assign lmsm_reg     = rst_n ? reg_c : 3'd0;
    assign lmsm_offset  = rst_n ? off_c : 3'd0;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: cycle-by-cycle vector table plus a hand-written
// asynchronous-reset-mid-sequence check. A second instance with a 2-bit
// counter exercises stall_cnt saturation on the same stimulus.
`timescale 1ns/1ps
module tb_hazard_stall_unit;

    localparam logic [5:0] OP_ADD = 6'b0000_00;
    localparam logic [5:0] OP_ADZ = 6'b0000_01;
    localparam logic [5:0] OP_LHI = 6'b0011_00;
    localparam logic [5:0] OP_LW  = 6'b0100_00;
    localparam logic [5:0] OP_LM  = 6'b0110_00;
    localparam logic [5:0] OP_SM  = 6'b0111_00;
    localparam int         NV     = 22;

    logic        clk, rst_n, flush;
    logic [5:0]  id_rr_op, rr_ex_op;
    logic [2:0]  id_rr_regA, id_rr_regB, rr_ex_regA;
    logic [7:0]  id_rr_imm;
    logic        pc_stall, if_id_stall, id_rr_stall, rr_ex_bubble;
    logic        lmsm_valid, lmsm_first, lmsm_last;
    logic [2:0]  lmsm_reg, lmsm_offset;
    logic [15:0] stall_cnt;

    logic        s_pc, s_if, s_id, s_bub, s_val, s_first, s_last;
    logic [2:0]  s_reg, s_off;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic [2:0]  ra, rb;
        logic [7:0]  imm;
        logic [5:0]  ex_op;
        logic [2:0]  ex_ra;
        logic        flush;
        logic [12:0] exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[NV];

    hazard_stall_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rr_op(id_rr_op), .id_rr_regA(id_rr_regA),
        .id_rr_regB(id_rr_regB), .id_rr_imm(id_rr_imm), .rr_ex_op(rr_ex_op),
        .rr_ex_regA(rr_ex_regA), .flush(flush), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .id_rr_stall(id_rr_stall),
        .rr_ex_bubble(rr_ex_bubble), .lmsm_valid(lmsm_valid), .lmsm_reg(lmsm_reg),
        .lmsm_offset(lmsm_offset), .lmsm_first(lmsm_first), .lmsm_last(lmsm_last),
        .stall_cnt(stall_cnt)
    );

    hazard_stall_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rr_op(id_rr_op), .id_rr_regA(id_rr_regA),
        .id_rr_regB(id_rr_regB), .id_rr_imm(id_rr_imm), .rr_ex_op(rr_ex_op),
        .rr_ex_regA(rr_ex_regA), .flush(flush), .pc_stall(s_pc),
        .if_id_stall(s_if), .id_rr_stall(s_id), .rr_ex_bubble(s_bub),
        .lmsm_valid(s_val), .lmsm_reg(s_reg), .lmsm_offset(s_off),
        .lmsm_first(s_first), .lmsm_last(s_last), .stall_cnt(s_cnt)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: {pc, if_id, id_rr stall, bubble, valid, reg, offset, first, last}.
    function automatic logic [12:0] ex(input logic s, b, v, input logic [2:0] r, o,
                                       input logic f, l);
        return {s, s, s, b, v, r, o, f, l};
    endfunction

    function automatic logic [12:0] got_out();
        return {pc_stall, if_id_stall, id_rr_stall, rr_ex_bubble, lmsm_valid,
                lmsm_reg, lmsm_offset, lmsm_first, lmsm_last};
    endfunction

    function automatic vec_t mk(input logic rn, input logic [5:0] op, input logic [2:0] ra, rb,
                                input logic [7:0] imm, input logic [5:0] eop,
                                input logic [2:0] era, input logic fl,
                                input logic [12:0] eo, input logic [15:0] ec);
        vec_t v;
        v.rst_n = rn; v.op = op; v.ra = ra; v.rb = rb; v.imm = imm;
        v.ex_op = eop; v.ex_ra = era; v.flush = fl; v.exp_out = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n      = v.rst_n;
        id_rr_op   = v.op;
        id_rr_regA = v.ra;
        id_rr_regB = v.rb;
        id_rr_imm  = v.imm;
        rr_ex_op   = v.ex_op;
        rr_ex_regA = v.ex_ra;
        flush      = v.flush;
    endtask

    task automatic check_all(input string name, input logic [12:0] eo, input logic [15:0] ec);
        logic [15:0] sat;
        sat = (ec > 16'd3) ? 16'd3 : ec;
        check({name, " out"}, 32'(got_out()), 32'(eo));
        check({name, " cnt"}, 32'(stall_cnt), 32'(ec));
        check({name, " sat"}, 32'(s_cnt), 32'(sat));
    endtask

    initial begin
        // One row per cycle; outputs and pre-edge counter value checked mid-cycle.
        vecs[0]  = mk(0, OP_ADD, 3, 2, 8'h00, OP_LW,  3, 0, ex(0,0,0,0,0,0,0), 0);
        vecs[1]  = mk(1, OP_ADD, 3, 2, 8'h00, OP_LW,  3, 0, ex(1,1,0,0,0,0,0), 0);
        vecs[2]  = mk(1, OP_ADD, 3, 2, 8'h00, OP_LHI, 0, 0, ex(0,0,0,0,0,0,0), 1);
        vecs[3]  = mk(1, OP_ADD, 3, 2, 8'h00, OP_LW,  2, 0, ex(1,1,0,0,0,0,0), 1);
        vecs[4]  = mk(1, OP_ADZ, 1, 2, 8'h00, OP_LW,  5, 0, ex(1,1,0,0,0,0,0), 2);
        vecs[5]  = mk(1, OP_ADD, 1, 2, 8'h00, OP_LW,  5, 0, ex(0,0,0,0,0,0,0), 3);
        vecs[6]  = mk(1, OP_LHI, 4, 4, 8'h00, OP_LW,  4, 0, ex(0,0,0,0,0,0,0), 3);
        vecs[7]  = mk(1, OP_LM,  0, 0, 8'hA5, OP_LHI, 0, 0, ex(1,0,1,0,0,1,0), 3);
        vecs[8]  = mk(1, OP_LM,  0, 0, 8'hA5, OP_LM,  0, 0, ex(1,0,1,2,1,0,0), 4);
        vecs[9]  = mk(1, OP_LM,  0, 0, 8'hA5, OP_LM,  0, 0, ex(1,0,1,5,2,0,0), 5);
        vecs[10] = mk(1, OP_LM,  0, 0, 8'hA5, OP_LM,  0, 0, ex(0,0,1,7,3,0,1), 6);
        vecs[11] = mk(1, OP_SM,  0, 0, 8'h00, OP_LM,  0, 0, ex(0,1,0,0,0,0,0), 6);
        vecs[12] = mk(1, OP_SM,  0, 0, 8'h80, OP_LHI, 0, 0, ex(0,0,1,7,0,1,1), 6);
        vecs[13] = mk(1, OP_LM,  0, 0, 8'hFF, OP_SM,  0, 0, ex(1,0,1,0,0,1,0), 6);
        vecs[14] = mk(1, OP_LM,  0, 0, 8'hFF, OP_LM,  0, 0, ex(1,0,1,1,1,0,0), 7);
        vecs[15] = mk(1, OP_LM,  0, 0, 8'hFF, OP_LM,  0, 1, ex(0,1,0,0,0,0,0), 8);
        vecs[16] = mk(1, OP_LM,  0, 0, 8'h03, OP_LHI, 0, 0, ex(1,0,1,0,0,1,0), 8);
        vecs[17] = mk(1, OP_LM,  0, 0, 8'h03, OP_LM,  0, 0, ex(0,0,1,1,1,0,1), 9);
        vecs[18] = mk(1, OP_LM,  4, 0, 8'h06, OP_LW,  4, 0, ex(1,1,0,0,0,0,0), 9);
        vecs[19] = mk(1, OP_LM,  4, 0, 8'h06, OP_LHI, 0, 0, ex(1,0,1,1,0,1,0), 10);
        vecs[20] = mk(1, OP_LM,  4, 0, 8'h06, OP_LM,  0, 0, ex(0,0,1,2,1,0,1), 11);
        vecs[21] = mk(1, OP_ADD, 4, 0, 8'h00, OP_LW,  4, 1, ex(0,1,0,0,0,0,0), 11);

        rst_n = 1'b1; flush = 1'b0;
        id_rr_op = OP_LHI; id_rr_regA = 0; id_rr_regB = 0; id_rr_imm = 0;
        rr_ex_op = OP_LHI; rr_ex_regA = 0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check_all($sformatf("row%0d", i), vecs[i].exp_out, vecs[i].exp_cnt);
        end

        // Async reset in the middle of an LM 0xFF sequence.
        @(posedge clk); #1;
        id_rr_op = OP_LM; id_rr_regA = 0; id_rr_imm = 8'hFF;
        rr_ex_op = OP_LHI; flush = 1'b0;
        @(negedge clk);
        check_all("rst_pre_seq0", ex(1,0,1,0,0,1,0), 11);
        @(posedge clk); #1;
        rr_ex_op = OP_LM;
        check_all("rst_pre_seq1", ex(1,0,1,1,1,0,0), 12);
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid_seq", ex(0,0,0,0,0,0,0), 0);
        @(posedge clk); #1;
        check_all("rst_held", ex(0,0,0,0,0,0,0), 0);
        #3 rst_n = 1'b1;
        id_rr_imm = 8'h10; rr_ex_op = OP_LHI;
        @(negedge clk);
        check_all("post_rst_single", ex(0,0,1,4,0,1,1), 0);
        @(posedge clk); #1;
        id_rr_op = OP_LHI; id_rr_imm = 8'h00; rr_ex_op = OP_LM;
        @(negedge clk);
        check_all("post_rst_idle", ex(0,0,0,0,0,0,0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Interlock and multi-cycle sequencer in the register-read (RR) stage of the 6-stage pipeline. It covers the hazards that execute-stage forwarding cannot resolve. It detects load-use hazards and holds PC, IF/ID and ID/RR for one cycle while injecting a bubble into RR/EX. It also expands LM/SM into one micro-op per set bit of the 8-bit register mask, stalling upstream until the last micro-op issues.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rr_op`  in  6  {opcode[3:0], cz[1:0]} of the instruction in RR.
- `id_rr_regA`, `id_rr_regB`  in  3 each  source fields of the RR instruction.
- `id_rr_imm`  in  8  LM/SM register mask; bit i selects R(i).
- `rr_ex_op`  in  6  op of the instruction in EX.
- `rr_ex_regA`  in  3  destination of the instruction in EX (for LW).
- `flush`  in  1  taken branch/jump redirect from EX or MEM.
- `pc_stall`, `if_id_stall`, `id_rr_stall`  out  1 each  hold the corresponding register.
- `rr_ex_bubble`  out  1  load a NOP into RR/EX this cycle.
- `lmsm_valid`  out  1  current RR/EX load is an LM/SM micro-op.
- `lmsm_reg`  out  3  register index of the current micro-op.
- `lmsm_offset`  out  3  address offset (0..7) of the current micro-op.
- `lmsm_first`, `lmsm_last`  out  1 each  first and last micro-op markers.
- `stall_cnt`  out  CNT_W  total stalled cycles, saturating.

Opcodes: LW=0100, LM=0110, SM=0111, ADZ=000001, NDZ=001001.

## Operation
- Load-use hazard (`lu`), evaluated combinationally. It requires `rr_ex_op[5:2]`==LW, plus one of the following:
  - `rr_ex_regA`==`id_rr_regA` and RR op reads regA. Readers of regA: ADD, ADC, ADZ, NDU, NDC, NDZ, ADI, LM, SM, SW, BEQ.
  - `rr_ex_regA`==`id_rr_regB` and RR op reads regB. Readers of regB: the R-type ops, LW, SW, BEQ, JLR.
  - RR op is ADZ or NDZ. These need the load's zero flag, so they stall whenever EX holds LW, regardless of register match.
- While `lu`=1:
  - `pc_stall`, `if_id_stall` and `id_rr_stall` are 1.
  - `rr_ex_bubble`=1.
  - No LM/SM start.
- FSM states: IDLE and SEQ. Registers: `mask_q[7:0]`, `off_q[2:0]`.
- IDLE, RR op is LM/SM, `lu`=0, `flush`=0:
  - Mask 0: `rr_ex_bubble`=1, `lmsm_valid`=0, no stall.
  - Mask nonzero: `lmsm_valid`=1, `lmsm_first`=1, `lmsm_offset`=0. `lmsm_reg` is the index of the lowest set bit.
  - Exactly one bit set: `lmsm_last`=1, no stall, stay in IDLE.
  - Otherwise: stall upstream, set `mask_q` = mask with the lowest bit cleared, set `off_q`=1, go to SEQ.
- SEQ:
  - Outputs: `lmsm_valid`=1, `lmsm_reg` = lowest set bit of `mask_q`, `lmsm_offset`=`off_q`.
  - Update: clear that bit in `mask_q`, increment `off_q`.
  - Upstream stall stays 1 while more than one bit remains in `mask_q`.
  - Last bit: `lmsm_last`=1, upstream stall 0, next state IDLE.
- Priority: `flush` > `lu` > LM/SM sequencing.
- `flush`=1 in any state:
  - All stalls 0, `rr_ex_bubble`=1, `lmsm_valid`=0.
  - Next state IDLE; `mask_q` and `off_q` cleared.
- `stall_cnt` increments in every cycle with `pc_stall`=1 and holds at all-ones.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State IDLE; `mask_q`, `off_q` and `stall_cnt` = 0.
  - All outputs 0 while `rst_n` is low, regardless of other inputs.
- Reset asserted mid-SEQ aborts the sequence immediately; no further micro-ops.
- Stall and bubble outputs are combinational from the current state and inputs (Mealy), with zero-cycle latency.
- Load-use costs exactly 1 cycle. In the next cycle, EX holds the bubble and `lu` drops.
- An LM/SM with N set bits occupies RR for N cycles and issues N micro-ops in ascending register order. It stalls upstream for N-1 cycles.
- LM/SM with a base load-use hazard: 1 bubble cycle first, then the sequence starts.
- After the last micro-op, the next instruction enters RR on the following edge.

## Test plan
- LW R3 in EX, ADD R1=R3+R2 in RR → one cycle with stalls=1 and `rr_ex_bubble`=1; next cycle stalls=0; `stall_cnt`=1.
- LW R5 in EX, ADZ with no register match in RR → 1-cycle stall. ADD (cz=00) with no match → no stall.
- LM mask 8'b1010_0101 → 4 micro-ops:
  - `lmsm_reg` 0, 2, 5, 7 with `lmsm_offset` 0, 1, 2, 3.
  - `lmsm_first` on the 1st micro-op, `lmsm_last` on the 4th.
  - Upstream stall high for 3 cycles.
- SM mask 8'h00 → `rr_ex_bubble`=1, `lmsm_valid`=0, no stall. SM mask 8'h80 → single micro-op with reg 7, first=last=1, no stall.
- LM mask 8'hFF, `flush` asserted on the 3rd micro-op → bubble, stalls 0, IDLE next cycle. A following LM with mask 8'h03 issues regs 0, 1 with offsets 0, 1.
- `rst_n` pulsed low mid-SEQ (asynchronous, between edges) → outputs 0 immediately, `stall_cnt`=0. After release, a single-bit LM behaves as from IDLE.
